// File: rtl/uart_tx_usr_pkg.sv
// Shared types and helpers for the UART transmitter: shift-register modes,
// FSM states, frame length and frame-word formation.
package uart_tx_usr_pkg;

  localparam int unsigned FRAME_BITS = 11;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10
  } state_e;

  // Build the 11-bit load word; unused upper positions become extra stop bits.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] data,
                                                       input logic       eight,
                                                       input logic       pen,
                                                       input logic       ohel);
    logic par;
    par = (eight ? ^data : ^data[6:0]) ^ ohel;
    case ({eight, pen})
      2'b11:   return {1'b1, par, data, 1'b0};
      2'b10:   return {2'b11, data, 1'b0};
      2'b01:   return {2'b11, par, data[6:0], 1'b0};
      default: return {3'b111, data[6:0], 1'b0};
    endcase
  endfunction

  // Per-bit 4:1 mode selector forming the register's next state.
  function automatic logic mode_mux(input mode_e sel,
                                    input logic  hold_in,
                                    input logic  shr_in,
                                    input logic  shl_in,
                                    input logic  load_in);
    case (sel)
      MODE_HOLD: return hold_in;
      MODE_SHR:  return shr_in;
      MODE_SHL:  return shl_in;
      default:   return load_in;
    endcase
  endfunction

endpackage

// File: rtl/usr_reg.sv
// Width-parameterised universal shift register (hold / shift right /
// shift left / parallel load); resets to all ones (idle line level).
module usr_reg
  import uart_tx_usr_pkg::*;
#(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   m,
  input  logic [W-1:0] d,
  input  logic         sir,
  input  logic         sil,
  output logic [W-1:0] q
);

  logic [W-1:0] right_in;
  logic [W-1:0] left_in;
  logic [W-1:0] q_nxt;

  assign right_in = {sir, q[W-1:1]};
  assign left_in  = {q[W-2:0], sil};

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign q_nxt[i] = mode_mux(mode_e'(m), q[i], right_in[i], left_in[i], d[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q <= '1;
    else          q <= q_nxt;
  end

endmodule

// File: rtl/uart_tx_usr.sv
// UART transmit engine: FSM plus baud/bit counters steering a universal
// shift register that serialises a start/data/parity/stop frame LSB-first.
module uart_tx_usr
  import uart_tx_usr_pkg::*;
#(
  parameter int unsigned BAUD_COUNT = 10417
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic       tx,
  output logic       tx_rdy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
  localparam int unsigned BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_COUNT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

  state_e                  state, state_nxt;
  mode_e                   mode;
  logic [BAUD_W-1:0]       baud_cnt, baud_nxt;
  logic [BIT_W-1:0]        bit_cnt, bit_nxt;
  logic                    rdy_nxt, done_nxt;
  logic [FRAME_BITS-1:0]   load_word;
  logic [FRAME_BITS-1:0]   sr;

  // Inputs are sampled into the register on the LOAD edge only.
  assign load_word = frame_word(tx_data, eight, pen, ohel);

  usr_reg #(.W(FRAME_BITS)) u_sr (
    .clk     (clk),
    .reset_n (reset_n),
    .m       (mode),
    .d       (load_word),
    .sir     (1'b1),
    .sil     (1'b1),
    .q       (sr)
  );

  assign tx = sr[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_rdy   <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_rdy   <= rdy_nxt;
      tx_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    mode      = MODE_HOLD;
    rdy_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy_nxt = 1'b1;
        if (tx_start) begin
          state_nxt = ST_LOAD;
          rdy_nxt   = 1'b0;
        end
      end
      ST_LOAD: begin
        mode      = MODE_LOAD;
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt = '0;
          mode     = MODE_SHR;
          if (bit_cnt == BIT_LAST) begin
            bit_nxt   = '0;
            state_nxt = ST_IDLE;
            rdy_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt + BAUD_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        rdy_nxt   = 1'b1;
      end
    endcase
  end

endmodule
